// File: rtl/uart_program_sender.sv
// ---------------------------------------------------------------------------
// uart_program_sender
//
// Host-side program loader. On start it transmits a boot image over an 8N1
// UART line: sync byte 0xAA, a 32-bit little-endian word count, then the
// program words (each little-endian) read from an external registered memory.
// It then waits for the 0xAA acknowledge from a companion uart_rx.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      1-cycle pulse, accepted only in IDLE
//   num_words  number of program words, sampled on an accepted start
//   mem_addr   program memory word address
//   mem_data   program word, valid one cycle after mem_addr changes
//   txd        UART transmit line, idle high, registered
//   rx_data    byte from the external uart_rx
//   rx_valid   1-cycle strobe qualifying rx_data
//   busy       high from accepted start until DONE/ERROR is entered
//   done       1-cycle pulse on a correct acknowledge
//   err        sticky; ack timeout or wrong ack byte, cleared by next start
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | line idle, waiting for start
// SYNC     | launching the 0xAA sync frame
// LEN      | sending the 4 bytes of the word count
// FETCH    | latching the prefetched word, advancing mem_addr
// WORD     | sending the 4 bytes of the latched word
// WAIT_ACK | line idle, waiting for the acknowledge byte or timeout
// DONE     | done pulse, back to IDLE
// ERROR    | err set, back to IDLE
// ---------------------------------------------------------------------------
module uart_program_sender #(
   parameter int          CLK_PER_HALF_BIT = 434,
   parameter int          ADDR_W           = 15,
   parameter logic [31:0] ACK_TIMEOUT      = 32'd100_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_words,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic              txd,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
   localparam int BAUD_W   = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 2;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_LEN,
      S_FETCH,
      S_WORD,
      S_WAIT_ACK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] nwords_q;
   logic [ADDR_W-1:0] words_sent;
   logic [31:0]       word_sr;
   logic [2:0]        byte_cnt;
   logic [31:0]       ack_cnt;

   // serializer
   logic [8:0]        tx_sr;
   logic [3:0]        bit_cnt;
   logic [BAUD_W-1:0] baud_cnt;
   logic              tx_active;

   logic              frame_end;
   logic              tx_ready;
   logic              stop_lead;
   logic              last_word;
   logic              ld;
   logic [7:0]        ld_byte;

   // frame_end is the final clock of a stop bit; a byte loaded then starts
   // its start bit on the very next clock, so back-to-back frames have no gap.
   assign frame_end = tx_active && (baud_cnt == '0) && (bit_cnt == 4'd9);
   assign tx_ready  = !tx_active || frame_end;

   // Two clocks before frame_end: enter FETCH here so the fetch cycle and the
   // WORD launch both land inside the last stop bit.
   assign stop_lead = tx_active && (baud_cnt == BAUD_W'(2)) && (bit_cnt == 4'd9);

   assign last_word = (state == S_LEN) ? (nwords_q == '0) : (words_sent == nwords_q);

   always_comb begin
      ld      = 1'b0;
      ld_byte = 8'h00;
      case (state)
         S_SYNC: begin
            if (tx_ready) begin
               ld      = 1'b1;
               ld_byte = 8'hAA;
            end
         end
         S_LEN, S_WORD: begin
            if (tx_ready && (byte_cnt != 3'd4)) begin
               ld      = 1'b1;
               ld_byte = word_sr[7:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         nwords_q   <= '0;
         words_sent <= '0;
         word_sr    <= '0;
         byte_cnt   <= '0;
         ack_cnt    <= '0;
         mem_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         tx_sr      <= '1;
         bit_cnt    <= '0;
         baud_cnt   <= '0;
         tx_active  <= 1'b0;
         txd        <= 1'b1;
      end else begin
         // serializer: start bit, 8 data bits LSB first, stop bit
         if (ld) begin
            tx_sr     <= {1'b1, ld_byte};
            txd       <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= BAUD_LAST;
            tx_active <= 1'b1;
         end else if (tx_active) begin
            if (baud_cnt == '0) begin
               if (bit_cnt == 4'd9) begin
                  tx_active <= 1'b0;
               end else begin
                  txd      <= tx_sr[0];
                  tx_sr    <= {1'b1, tx_sr[8:1]};
                  bit_cnt  <= bit_cnt + 4'd1;
                  baud_cnt <= BAUD_LAST;
               end
            end else begin
               baud_cnt <= baud_cnt - BAUD_W'(1);
            end
         end

         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  nwords_q   <= num_words;
                  words_sent <= '0;
                  mem_addr   <= '0;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_SYNC;
               end
            end

            S_SYNC: begin
               if (ld) begin
                  word_sr  <= 32'(nwords_q);
                  byte_cnt <= '0;
                  state    <= S_LEN;
               end
            end

            S_LEN, S_WORD: begin
               if (ld) begin
                  word_sr  <= {8'h00, word_sr[31:8]};
                  byte_cnt <= byte_cnt + 3'd1;
               end else if (byte_cnt == 3'd4) begin
                  if (last_word) begin
                     // ack window opens only once the final stop bit is out
                     if (frame_end) begin
                        ack_cnt <= '0;
                        state   <= S_WAIT_ACK;
                     end
                  end else if (stop_lead) begin
                     state <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               // mem_addr has been stable for a whole frame, so mem_data
               // already holds this word; advancing mem_addr prefetches the next.
               word_sr    <= mem_data;
               mem_addr   <= mem_addr + ADDR_W'(1);
               words_sent <= words_sent + ADDR_W'(1);
               byte_cnt   <= '0;
               state      <= S_WORD;
            end

            S_WAIT_ACK: begin
               // a byte arriving on the timeout cycle wins over the timeout
               if (rx_valid) begin
                  busy <= 1'b0;
                  if (rx_data == 8'hAA) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     err   <= 1'b1;
                     state <= S_ERROR;
                  end
               end else if (ack_cnt == ACK_TIMEOUT - 32'd1) begin
                  busy  <= 1'b0;
                  err   <= 1'b1;
                  state <= S_ERROR;
               end else begin
                  ack_cnt <= ack_cnt + 32'd1;
               end
            end

            S_DONE:  state <= S_IDLE;
            S_ERROR: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_program_sender.sv
module tb_uart_program_sender;

   localparam int HB    = 5;
   localparam int BIT   = 2 * HB;
   localparam int FRAME = 10 * BIT;
   localparam int AW    = 8;
   localparam int TMO   = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] num_words;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic          txd;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          busy;
   logic          done;
   logic          err;

   uart_program_sender #(
      .CLK_PER_HALF_BIT(HB),
      .ADDR_W(AW),
      .ACK_TIMEOUT(32'(TMO))
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .num_words(num_words),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .txd(txd),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   always @(posedge clk) mem_data <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- line monitors ----------------
   int   done_cnt = 0;
   int   busy_cnt = 0;
   int   err_rise_cyc = -1;
   int   busy_fall_cyc = -1;
   bit   addr_nz = 1'b0;
   logic prev_err = 1'b0;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && mem_addr !== '0) addr_nz = 1'b1;
      if (err === 1'b1 && prev_err !== 1'b1) err_rise_cyc = cyc;
      if (busy !== 1'b1 && prev_busy === 1'b1) busy_fall_cyc = cyc;
      prev_err  = err;
      prev_busy = busy;
   end

   // ---------------- UART decoder ----------------
   logic [7:0] byte_q [$];
   int         start_q [$];
   int         end_q [$];
   bit         tim_q [$];

   initial begin
      int         st;
      logic [9:0] bits;
      bit         ok;
      bit         ab;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1 && txd === 1'b0) begin
            st = cyc;
            ok = 1'b1;
            ab = 1'b0;
            bits = '0;
            for (int k = 0; k < 10; k++) begin
               for (int c = 0; c < BIT; c++) begin
                  if (k != 0 || c != 0) @(negedge clk);
                  if (rst === 1'b1) begin
                     ab = 1'b1;
                     break;
                  end
                  if (c == 0) bits[k] = txd;
                  else if (txd !== bits[k]) ok = 1'b0;
               end
               if (ab) break;
            end
            if (!ab) begin
               if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
               byte_q.push_back(bits[8:1]);
               start_q.push_back(st);
               end_q.push_back(cyc);
               tim_q.push_back(ok);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic clear_mon();
      byte_q.delete();
      start_q.delete();
      end_q.delete();
      tim_q.delete();
      done_cnt = 0;
      busy_cnt = 0;
      addr_nz  = 1'b0;
      err_rise_cyc  = -1;
      busy_fall_cyc = -1;
   endtask

   task automatic do_start(input logic [AW-1:0] n);
      @(negedge clk);
      num_words = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int k;
      k = 0;
      while (byte_q.size() < n && k < (n + 2) * FRAME + 100) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_nbytes"}, 64'(byte_q.size()), 64'(n));
   endtask

   // called at a negedge; drives the strobe for exactly one clock
   task automatic send_ack(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Reference: the boot image is AA, count LE, then every word LE.
   task automatic check_stream(input string tag, input int n);
      logic [7:0] exp_q [$];
      bit tok;
      bit gok;
      exp_q.push_back(8'hAA);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((n >> (8 * i)) & 255));
      for (int w = 0; w < n; w++)
         for (int b = 0; b < 4; b++)
            exp_q.push_back(8'((mem[w % 256] >> (8 * b)) & 32'hFF));
      chk({tag, "_len"}, 64'(byte_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < byte_q.size())
            chk($sformatf("%s_byte%0d", tag, i), 64'(byte_q[i]), 64'(exp_q[i]));
      tok = 1'b1;
      foreach (tim_q[i]) if (!tim_q[i]) tok = 1'b0;
      chk({tag, "_bit_timing"}, 64'(tok), 64'(1));
      gok = 1'b1;
      for (int i = 1; i < start_q.size(); i++)
         if (start_q[i] != end_q[i-1] + 1) gok = 1'b0;
      chk({tag, "_no_gap"}, 64'(gok), 64'(1));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int last_end;
      int k;

      rst = 1'b1;
      start = 1'b0;
      num_words = '0;
      rx_data = 8'h00;
      rx_valid = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      repeat (3) @(negedge clk);
      chk("rst_txd", 64'(txd), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_txd", 64'(txd), 64'(1));

      // 1: two words, ack 100 clocks after the last stop bit
      mem[0] = 32'h2001_0005;
      mem[1] = 32'hFC00_0000;
      clear_mon();
      do_start(2);
      wait_bytes(13, "t1");
      last_end = end_q[end_q.size() - 1];
      while (cyc < last_end + 100) @(negedge clk);
      send_ack(8'hAA);
      repeat (3) @(negedge clk);
      check_stream("t1", 2);
      chk("t1_done_cnt", 64'(done_cnt), 64'(1));
      chk("t1_err", 64'(err), 64'(0));
      chk("t1_busy_cycles", 64'(busy_cnt), 64'(13 * FRAME + 1 + 100));
      chk("t1_busy_low", 64'(busy), 64'(0));

      // 2: zero words
      clear_mon();
      do_start(0);
      wait_bytes(5, "t2");
      repeat (20) @(negedge clk);
      send_ack(8'hAA);
      repeat (3) @(negedge clk);
      check_stream("t2", 0);
      chk("t2_addr_zero", 64'(addr_nz), 64'(0));
      chk("t2_done_cnt", 64'(done_cnt), 64'(1));

      // 3: wrong ack, then a clean retry
      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      n = $urandom_range(1, 3);
      clear_mon();
      do_start(AW'(n));
      wait_bytes(5 + 4 * n, "t3a");
      repeat (10) @(negedge clk);
      send_ack(8'h55);
      repeat (3) @(negedge clk);
      check_stream("t3a", n);
      chk("t3_err_set", 64'(err), 64'(1));
      chk("t3_no_done", 64'(done_cnt), 64'(0));
      chk("t3_busy_low", 64'(busy), 64'(0));
      n = $urandom_range(1, 3);
      clear_mon();
      do_start(AW'(n));
      chk("t3_err_cleared", 64'(err), 64'(0));
      wait_bytes(5 + 4 * n, "t3b");
      repeat (7) @(negedge clk);
      send_ack(8'hAA);
      repeat (3) @(negedge clk);
      check_stream("t3b", n);
      chk("t3b_done_cnt", 64'(done_cnt), 64'(1));
      chk("t3b_err", 64'(err), 64'(0));

      // 4: no acknowledge
      clear_mon();
      do_start(1);
      wait_bytes(9, "t4");
      last_end = end_q[end_q.size() - 1];
      k = 0;
      while (err !== 1'b1 && k < TMO + 200) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      chk("t4_err_cycle", 64'(err_rise_cyc), 64'(last_end + 1 + TMO));
      chk("t4_busy_fall", 64'(busy_fall_cyc), 64'(err_rise_cyc));
      chk("t4_no_done", 64'(done_cnt), 64'(0));
      check_stream("t4", 1);

      // 5: reset during bit 3 of the first LEN frame (count 3 -> that bit is 0)
      clear_mon();
      do_start(3);
      wait_bytes(1, "t5");
      last_end = end_q[0];
      while (cyc < last_end + 1 + 3 * BIT + BIT / 2) @(negedge clk);
      chk("t5_txd_before", 64'(txd), 64'(0));
      #2 rst = 1'b1;
      #1;
      chk("t5_txd_async", 64'(txd), 64'(1));
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_done", 64'(done), 64'(0));
      chk("t5_err", 64'(err), 64'(0));
      chk("t5_addr", 64'(mem_addr), 64'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
      chk("t5_silent", 64'(byte_q.size()), 64'(1));
      clear_mon();
      do_start(1);
      wait_bytes(9, "t5b");
      repeat (5) @(negedge clk);
      send_ack(8'hAA);
      repeat (3) @(negedge clk);
      check_stream("t5b", 1);
      chk("t5b_done_cnt", 64'(done_cnt), 64'(1));

      // 6: rx_valid and start pulses mid-transfer are ignored
      for (int i = 0; i < 2; i++) mem[i] = $urandom;
      clear_mon();
      do_start(2);
      wait_bytes(6, "t6a");
      rx_data = 8'hAA;
      rx_valid = 1'b1;
      num_words = 8'd5;
      start = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      start = 1'b0;
      wait_bytes(10, "t6b");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_bytes(13, "t6c");
      chk("t6_busy_held", 64'(busy), 64'(1));
      chk("t6_no_early_done", 64'(done_cnt), 64'(0));
      repeat (30) @(negedge clk);
      send_ack(8'hAA);
      repeat (3) @(negedge clk);
      check_stream("t6", 2);
      chk("t6_done_cnt", 64'(done_cnt), 64'(1));

      // random transfers
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) mem[i] = $urandom;
         clear_mon();
         do_start(AW'(n));
         wait_bytes(5 + 4 * n, $sformatf("rnd%0d", r));
         repeat ($urandom_range(1, 50)) @(negedge clk);
         send_ack(8'hAA);
         repeat (3) @(negedge clk);
         check_stream($sformatf("rnd%0d", r), n);
         chk($sformatf("rnd%0d_done", r), 64'(done_cnt), 64'(1));
         chk($sformatf("rnd%0d_err", r), 64'(err), 64'(0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_program_sender.md
Name: uart_program_sender

Overview:
- Host-side counterpart of the core's UART program loader; fills the loader role in system-level benches and in the board-to-board loader.
- On `start` it performs the boot handshake and streams a program image out over `txd`:
  - sync byte 0xAA;
  - 32-bit word count;
  - the instruction words from a local ROM/BRAM.
- It then waits for the core's 0xAA acknowledge, which arrives as bytes from a companion `uart_rx` instance.
- Includes its own 8N1 bit serializer.

Parameters:
- `CLK_PER_HALF_BIT`, 434, clocks per half UART bit; one bit period = 2*`CLK_PER_HALF_BIT` clocks.
- `ADDR_W`, 15, width of the word address into program memory.
- `ACK_TIMEOUT`, 32'd100_000_000, clocks to wait for the acknowledge before flagging an error.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  1-cycle pulse; begins a transfer when idle
- `num_words`  in  `ADDR_W`  words to send; sampled on `start`
- `mem_addr`  out  `ADDR_W`  program memory word address
- `mem_data`  in  32  program word; valid exactly 1 cycle after `mem_addr` changes (registered read)
- `txd`  out  1  UART transmit line, idle high
- `rx_data`  in  8  byte from external `uart_rx`
- `rx_valid`  in  1  1-cycle strobe, `rx_data` valid
- `busy`  out  1  high from accepted `start` until DONE/ERROR is entered
- `done`  out  1  1-cycle pulse: acknowledge 0xAA received
- `err`  out  1  sticky; acknowledge timeout or wrong ack byte; cleared by the next accepted `start`

Behaviour:

Reset (async, `rst`=1): state IDLE; `txd`=1, `busy`=0, `done`=0, `err`=0, `mem_addr`=0; bit/byte/word counters 0. Reset asserted mid-frame aborts immediately, with `txd` forced high.

Serializer:
- Frame = start bit 0, data bits LSB first, stop bit 1; each bit held exactly 2*`CLK_PER_HALF_BIT` clocks.
- The next frame's start bit follows the previous stop bit with no extra gap.
- Frame length is 10 bit periods = 8680 clocks at default.

States:
- IDLE:
  - `start`=1 → latch `num_words`; clear `err`; `busy`=1; `mem_addr`=0; go to SYNC.
  - `start` is ignored in every other state.
- SYNC: transmit 0xAA → LEN.
- LEN: transmit `num_words` zero-extended to 32 bits, as 4 bytes, least-significant first.
  - `num_words`=0 → go directly to WAIT_ACK.
  - Otherwise → FETCH.
- FETCH:
  - One wait cycle for `mem_data`, then latch the word into the shift register.
  - Increment `mem_addr` in the same cycle, so the next word is prefetched.
  - → WORD.
- WORD: transmit the 4 bytes of the latched word, LSB byte first.
  - After the last byte, if words sent == `num_words` → WAIT_ACK; else → FETCH.
  - The FETCH cycle falls inside the last stop bit of the previous word; inter-word gap is 0.
- WAIT_ACK:
  - Timeout counter starts at 0 on entry.
  - `rx_valid` with `rx_data`==8'hAA → DONE.
  - `rx_valid` with any other byte → ERROR.
  - Counter reaching `ACK_TIMEOUT`-1 → ERROR.
  - `rx_valid` coinciding with the timeout cycle: the byte takes priority.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- ERROR: `err`=1 (sticky), `busy`=0 → IDLE.

Other rules:
- `rx_valid` outside WAIT_ACK is ignored. This covers the core's echo and any noise during transmission.
- `mem_addr` wraps modulo 2^`ADDR_W`; `num_words`=2^`ADDR_W`-1 is the maximum.
- `txd` is registered: no glitches and no combinational path from state.

Test Plan:
1. `num_words`=2, mem[0]=32'h2001_0005, mem[1]=32'hFC00_0000; `rx_data`=AA pulsed 100 clocks after the last stop bit.
   - `txd` decodes to bytes AA, 02, 00, 00, 00, 05, 00, 01, 20, 00, 00, 00, FC.
   - `done` pulses once; `err`=0.
   - `busy` is high for exactly 13 frames plus the wait time.
2. `num_words`=0, then ack AA.
   - Only AA, 00, 00, 00, 00 are sent; `mem_addr` stays 0; `done`=1.
3. Acknowledge byte 0x55 in WAIT_ACK.
   - `err`=1, `done` never pulses.
   - A second `start` clears `err` and the transfer proceeds normally.
4. No acknowledge, `ACK_TIMEOUT`=1000.
   - `err` rises exactly 1000 clocks after WAIT_ACK entry; `busy` falls in the same cycle.
5. `rst` pulsed during bit 3 of the LEN frame.
   - `txd`=1 asynchronously; state IDLE; all outputs at reset values.
   - A fresh `start` restarts from the AA sync byte.
6. `rx_valid`=1 with AA during WORD, plus `start` pulses mid-transfer.
   - Both are ignored; the frame sequence is unchanged.
   - Bit timing is checked at 868±0 clocks per bit for every frame.
